pwr_seq_nrail: RTL and testbench

- Generalised master power sequencer that brings up NUM_RAILS rails in index order.
- Per rail: assert enable, wait for power-good within a timeout, then hold a per-rail settle delay before starting the next rail.
- Monitors every enabled rail for runtime power-good loss and powers down in reverse order. Supports an emergency (leak) shutdown.
- Latches the fault rail index and fault type for the BMC/UFM fault log.
- Sits between the AUX/leak front end and the node/NIC rail enables.

---
 rtl/pwr_seq_pkg.sv | 37 +++
 rtl/ms_tick_cnt.sv | 29 ++
 rtl/pwr_seq_nrail.sv | 239 +++++++++++++++++++++++
 tb/tb_pwr_seq_nrail.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the n-rail power sequencer: state codes, fault types, delay constants.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    StOn     = 4'h0,
    StPwrDn  = 4'h2,
    StSettle = 4'h3,
    StPwrUp  = 4'h5,
    StIdle   = 4'h9,
    StFault  = 4'hF
  } seq_state_e;

  localparam logic [1:0] FltNone      = 2'd0;
  localparam logic [1:0] FltUpTimeout = 2'd1;
  localparam logic [1:0] FltPgLoss    = 2'd2;
  localparam logic [1:0] FltDnEmerg   = 2'd3;

  // Rail index reported for an emergency shutdown; no real rail uses it.
  localparam logic [2:0] EmergRail = 3'd7;

  localparam logic [15:0] dly_0ms   = 16'd0;
  localparam logic [15:0] dly_1ms   = 16'd1;
  localparam logic [15:0] dly_10ms  = 16'd10;
  localparam logic [15:0] dly_100ms = 16'd100;
  localparam logic [15:0] dly_1s    = 16'd1000;
  localparam logic [15:0] dly_10s   = 16'd10000;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = i[2:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ms_tick_cnt.sv
// Clearable saturating millisecond counter with a count >= limit flag.
module ms_tick_cnt #(
  parameter int unsigned DLY_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic [DLY_W-1:0] limit_i,
  output logic             ge_o
);

  logic [DLY_W-1:0] cnt_q, cnt_d, cnt_eff;

  // A clear takes effect immediately so the flag never reflects a stale count.
  always_comb begin
    cnt_eff = clr_i ? '0 : cnt_q;
    cnt_d   = cnt_eff;
    if (tick_i && (cnt_eff != '1)) cnt_d = cnt_eff + DLY_W'(1);
  end

  assign ge_o = (cnt_eff >= limit_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwr_seq_nrail.sv
// Master power sequencer: ordered rail bring-up with PG timeouts, reverse-order power-down,
// runtime PG-loss and emergency shutdown with a first-fault latch.
module pwr_seq_nrail
  import pwr_seq_pkg::*;
#(
  parameter int unsigned                   NUM_RAILS     = 4,
  parameter int unsigned                   DLY_W         = 16,
  parameter logic [NUM_RAILS*DLY_W-1:0]    RAIL_DLY_MS   = {4{dly_10ms}},
  parameter logic [DLY_W-1:0]              PG_TIMEOUT_MS = dly_10s,
  parameter logic [DLY_W-1:0]              OFF_DLY_MS    = dly_1ms
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iTick_1ms,
  input  logic                 iPwr_Req,
  input  logic                 iEmerg_Off,
  input  logic                 iFault_Clr,
  input  logic [NUM_RAILS-1:0] iPwrgd,
  output logic [NUM_RAILS-1:0] oRail_En,
  output logic                 oAll_Pwrgd,
  output logic                 oFault_N,
  output logic [2:0]           oFault_Rail,
  output logic [1:0]           oFault_Type,
  output logic [3:0]           oDBG_FSM
);

  localparam logic [2:0]           LastIdx   = 3'(NUM_RAILS - 1);
  localparam logic [NUM_RAILS-1:0] FirstRail = {{(NUM_RAILS-1){1'b0}}, 1'b1};

  seq_state_e           state_q;
  logic [2:0]           idx_q;
  logic [NUM_RAILS-1:0] rail_en_q, sel_mask, nxt_mask, prv_mask;
  logic                 all_pwrgd_q, fault_n_q, dn_off_q, cnt_clr_q;
  logic [2:0]           fault_rail_q;
  logic [1:0]           fault_type_q;
  logic [7:0]           lost_all, lost_le, lost_lt;
  logic                 pg_cur, cnt_ge;
  logic [DLY_W-1:0]     dly_sel, cnt_limit;
  logic                 flt_hit;
  logic [1:0]           flt_type;
  logic [2:0]           flt_rail;

  always_comb begin
    sel_mask = '0;
    nxt_mask = '0;
    prv_mask = '0;
    lost_all = '0;
    lost_le  = '0;
    lost_lt  = '0;
    dly_sel  = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      sel_mask[i] = (int'(idx_q) == i);
      nxt_mask[i] = (int'(idx_q) + 1 == i);
      prv_mask[i] = (int'(idx_q) == i + 1);
      lost_all[i] = ~iPwrgd[i];
      lost_le[i]  = ~iPwrgd[i] & (i <= int'(idx_q));
      lost_lt[i]  = ~iPwrgd[i] & (i < int'(idx_q));
      if (int'(idx_q) == i) dly_sel = RAIL_DLY_MS[i*DLY_W +: DLY_W];
    end
  end

  assign pg_cur = |(iPwrgd & sel_mask);

  // During power-down the counter first times the PG fall, then the inter-rail gap.
  always_comb begin
    case (state_q)
      StSettle: cnt_limit = dly_sel;
      StPwrDn:  cnt_limit = dn_off_q ? OFF_DLY_MS : PG_TIMEOUT_MS;
      default:  cnt_limit = PG_TIMEOUT_MS;
    endcase
  end

  ms_tick_cnt #(
    .DLY_W (DLY_W)
  ) u_ms_cnt (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .tick_i  (iTick_1ms),
    .clr_i   (cnt_clr_q),
    .limit_i (cnt_limit),
    .ge_o    (cnt_ge)
  );

  // Fault detection in priority order: emergency, PG loss, timeout.
  always_comb begin
    flt_hit  = 1'b0;
    flt_type = FltNone;
    flt_rail = '0;
    if (iEmerg_Off && (state_q != StIdle) && (state_q != StFault)) begin
      flt_hit  = 1'b1;
      flt_type = FltDnEmerg;
      flt_rail = EmergRail;
    end else begin
      case (state_q)
        StPwrUp: begin
          if (|lost_lt) begin
            flt_hit  = 1'b1;
            flt_type = FltPgLoss;
            flt_rail = lowest_set(lost_lt);
          end else if (!pg_cur && cnt_ge) begin
            flt_hit  = 1'b1;
            flt_type = FltUpTimeout;
            flt_rail = idx_q;
          end
        end
        StSettle: begin
          if (|lost_le) begin
            flt_hit  = 1'b1;
            flt_type = FltPgLoss;
            flt_rail = lowest_set(lost_le);
          end
        end
        StOn: begin
          if (|lost_all) begin
            flt_hit  = 1'b1;
            flt_type = FltPgLoss;
            flt_rail = lowest_set(lost_all);
          end
        end
        StPwrDn: begin
          if (!dn_off_q && pg_cur && cnt_ge) begin
            flt_hit  = 1'b1;
            flt_type = FltDnEmerg;
            flt_rail = idx_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      rail_en_q    <= '0;
      all_pwrgd_q  <= 1'b0;
      fault_n_q    <= 1'b1;
      fault_rail_q <= '0;
      fault_type_q <= FltNone;
      dn_off_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
    end else begin
      cnt_clr_q   <= 1'b0;
      all_pwrgd_q <= 1'b0;
      if (flt_hit) begin
        state_q      <= StFault;
        rail_en_q    <= '0;
        fault_n_q    <= 1'b0;
        fault_rail_q <= flt_rail;
        fault_type_q <= flt_type;
      end else begin
        case (state_q)
          StIdle: begin
            if (iPwr_Req && !iEmerg_Off) begin
              state_q   <= StPwrUp;
              idx_q     <= '0;
              rail_en_q <= FirstRail;
              cnt_clr_q <= 1'b1;
            end
          end
          StPwrUp: begin
            if (pg_cur) begin
              state_q   <= StSettle;
              cnt_clr_q <= 1'b1;
            end else if (!iPwr_Req) begin
              state_q   <= StPwrDn;
              dn_off_q  <= 1'b0;
              rail_en_q <= rail_en_q & ~sel_mask;
              cnt_clr_q <= 1'b1;
            end
          end
          StSettle: begin
            if (cnt_ge) begin
              if (idx_q == LastIdx) begin
                state_q <= StOn;
              end else begin
                state_q   <= StPwrUp;
                idx_q     <= idx_q + 3'd1;
                rail_en_q <= rail_en_q | nxt_mask;
                cnt_clr_q <= 1'b1;
              end
            end else if (!iPwr_Req) begin
              state_q   <= StPwrDn;
              dn_off_q  <= 1'b0;
              rail_en_q <= rail_en_q & ~sel_mask;
              cnt_clr_q <= 1'b1;
            end
          end
          StOn: begin
            if (!iPwr_Req) begin
              state_q   <= StPwrDn;
              dn_off_q  <= 1'b0;
              rail_en_q <= rail_en_q & ~sel_mask;
              cnt_clr_q <= 1'b1;
            end else begin
              all_pwrgd_q <= 1'b1;
            end
          end
          StPwrDn: begin
            if (!dn_off_q) begin
              if (!pg_cur) begin
                if (idx_q == '0) begin
                  state_q <= StIdle;
                end else begin
                  dn_off_q  <= 1'b1;
                  cnt_clr_q <= 1'b1;
                end
              end
            end else if (cnt_ge) begin
              idx_q     <= idx_q - 3'd1;
              rail_en_q <= rail_en_q & ~prv_mask;
              dn_off_q  <= 1'b0;
              cnt_clr_q <= 1'b1;
            end
          end
          StFault: begin
            if (iFault_Clr && !iPwr_Req && !iEmerg_Off) begin
              state_q      <= StIdle;
              idx_q        <= '0;
              fault_n_q    <= 1'b1;
              fault_rail_q <= '0;
              fault_type_q <= FltNone;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign oRail_En    = rail_en_q;
  assign oAll_Pwrgd  = all_pwrgd_q;
  assign oFault_N    = fault_n_q;
  assign oFault_Rail = fault_rail_q;
  assign oFault_Type = fault_type_q;
  assign oDBG_FSM    = state_q;

endmodule

// File: tb/tb_pwr_seq_nrail.sv
// Directed bench for pwr_seq_nrail with a simple rail model (PG rises 2 ms after enable,
// falls on the first tick after disable). One ms tick every TickDiv clocks.
module tb_pwr_seq_nrail;

  localparam int NumRails = 4;
  localparam int TickDiv  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       pwr_req = 1'b0;
  logic       emerg = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] pg_kill = '0;
  logic [3:0] pg_block = '0;
  logic [3:0] pg_q = '0;
  logic [3:0] pwrgd;
  logic [3:0] rail_en;
  logic       all_pwrgd, fault_n;
  logic [2:0] fault_rail;
  logic [1:0] fault_type;
  logic [3:0] fsm;

  int n_checks = 0;
  int n_errors = 0;
  int ms_now = 0;
  int div = 0;
  int en_rise_ms [4] = '{default: 0};
  int en_fall_ms [4] = '{default: 0};
  int pwrgd_ms = 0;
  int fault_ms = 0;
  logic [3:0] en_prev = '0;
  logic       pwrgd_prev = 1'b0;
  logic       fault_n_prev = 1'b1;
  logic [1:0] up_ms [4] = '{default: 2'd0};

  assign pwrgd = pg_q & ~pg_kill;

  always #5 clk = ~clk;

  pwr_seq_nrail dut (
    .iClk        (clk),
    .iRst        (rst),
    .iTick_1ms   (tick),
    .iPwr_Req    (pwr_req),
    .iEmerg_Off  (emerg),
    .iFault_Clr  (fault_clr),
    .iPwrgd      (pwrgd),
    .oRail_En    (rail_en),
    .oAll_Pwrgd  (all_pwrgd),
    .oFault_N    (fault_n),
    .oFault_Rail (fault_rail),
    .oFault_Type (fault_type),
    .oDBG_FSM    (fsm)
  );

  always @(posedge clk) begin
    div  <= (div == TickDiv - 1) ? 0 : div + 1;
    tick <= (div == TickDiv - 1);
    if (tick) ms_now <= ms_now + 1;
  end

  always @(posedge clk) begin
    for (int k = 0; k < NumRails; k++) begin
      if (rail_en[k] && !pg_block[k]) begin
        if (tick) begin
          if (up_ms[k] == 2'd1) pg_q[k] <= 1'b1;
          if (up_ms[k] != 2'd3) up_ms[k] <= up_ms[k] + 2'd1;
        end
      end else begin
        up_ms[k] <= 2'd0;
        if (tick) pg_q[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NumRails; k++) begin
      if (rail_en[k] && !en_prev[k]) en_rise_ms[k] <= ms_now;
      if (!rail_en[k] && en_prev[k]) en_fall_ms[k] <= ms_now;
    end
    if (all_pwrgd && !pwrgd_prev) pwrgd_ms <= ms_now;
    if (!fault_n && fault_n_prev) fault_ms <= ms_now;
    en_prev      <= rail_en;
    pwrgd_prev   <= all_pwrgd;
    fault_n_prev <= fault_n;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_fsm(input logic [3:0] code, input int max_cyc, input string tag);
    for (int c = 0; c < max_cyc && fsm !== code; c++) @(negedge clk);
    check_eq(tag, 32'(fsm), 32'(code));
  endtask

  task automatic wait_en(input logic [3:0] val, input int max_cyc, input string tag);
    for (int c = 0; c < max_cyc && rail_en !== val; c++) @(negedge clk);
    check_eq(tag, 32'(rail_en), 32'(val));
  endtask

  task automatic wait_fault(input int max_cyc, input string tag);
    for (int c = 0; c < max_cyc && fault_n !== 1'b0; c++) @(negedge clk);
    check_eq(tag, 32'(fault_n), 32'd0);
  endtask

  task automatic clear_fault();
    pwr_req   = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    repeat (4 * TickDiv) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_en", 32'(rail_en), 32'd0);
    check_eq("rst_all_pwrgd", 32'(all_pwrgd), 32'd0);
    check_eq("rst_fault_n", 32'(fault_n), 32'd1);
    check_eq("rst_fault_type", 32'(fault_type), 32'd0);
    check_eq("rst_fault_rail", 32'(fault_rail), 32'd0);
    check_eq("rst_fsm", 32'(fsm), 32'h9);
    rst = 1'b0;

    // Emergency while idle only holds the sequencer in IDLE
    emerg   = 1'b1;
    pwr_req = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("idle_emerg_fsm", 32'(fsm), 32'h9);
    check_eq("idle_emerg_en", 32'(rail_en), 32'd0);
    check_eq("idle_emerg_fault_n", 32'(fault_n), 32'd1);
    emerg = 1'b0;

    // Full power-up
    wait_fsm(4'h0, 1000, "up_on_fsm");
    repeat (4) @(negedge clk);
    check_eq("up_en1_ms", 32'(en_rise_ms[1] - en_rise_ms[0]), 32'd12);
    check_eq("up_en2_ms", 32'(en_rise_ms[2] - en_rise_ms[0]), 32'd24);
    check_eq("up_en3_ms", 32'(en_rise_ms[3] - en_rise_ms[0]), 32'd36);
    check_eq("up_pwrgd_ms", 32'(pwrgd_ms - en_rise_ms[0]), 32'd48);
    check_eq("up_all_pwrgd", 32'(all_pwrgd), 32'd1);
    check_eq("up_en", 32'(rail_en), 32'hF);

    // Orderly power-down
    pwr_req = 1'b0;
    wait_fsm(4'h9, 400, "dn_idle_fsm");
    repeat (2) @(negedge clk);
    check_eq("dn_en2_ms", 32'(en_fall_ms[2] - en_fall_ms[3]), 32'd2);
    check_eq("dn_en1_ms", 32'(en_fall_ms[1] - en_fall_ms[3]), 32'd4);
    check_eq("dn_en0_ms", 32'(en_fall_ms[0] - en_fall_ms[3]), 32'd6);
    check_eq("dn_en", 32'(rail_en), 32'd0);
    check_eq("dn_all_pwrgd", 32'(all_pwrgd), 32'd0);
    check_eq("dn_fault_n", 32'(fault_n), 32'd1);
    repeat (4 * TickDiv) @(negedge clk);

    // Rail 2 never reaches power-good
    pg_block = 4'b0100;
    pwr_req  = 1'b1;
    wait_fault(45000, "to_fault_n");
    repeat (2) @(negedge clk);
    check_eq("to_ms", 32'(fault_ms - en_rise_ms[2]), 32'd10000);
    check_eq("to_type", 32'(fault_type), 32'd1);
    check_eq("to_rail", 32'(fault_rail), 32'd2);
    check_eq("to_en", 32'(rail_en), 32'd0);
    check_eq("to_fsm", 32'(fsm), 32'hF);
    pg_block = '0;
    clear_fault();
    check_eq("to_clr_fsm", 32'(fsm), 32'h9);
    check_eq("to_clr_type", 32'(fault_type), 32'd0);

    // Runtime PG glitch on rail 1, later loss of rail 3 must not overwrite it
    pwr_req = 1'b1;
    wait_fsm(4'h0, 1000, "rt_on_fsm");
    repeat (4) @(negedge clk);
    pg_kill = 4'b0010;
    @(negedge clk);
    pg_kill = '0;
    @(negedge clk);
    check_eq("rt_type", 32'(fault_type), 32'd2);
    check_eq("rt_rail", 32'(fault_rail), 32'd1);
    check_eq("rt_fault_n", 32'(fault_n), 32'd0);
    check_eq("rt_en", 32'(rail_en), 32'd0);
    check_eq("rt_all_pwrgd", 32'(all_pwrgd), 32'd0);
    pg_kill = 4'b1000;
    repeat (3) @(negedge clk);
    pg_kill = '0;
    check_eq("rt_keep_type", 32'(fault_type), 32'd2);
    check_eq("rt_keep_rail", 32'(fault_rail), 32'd1);
    clear_fault();

    // Emergency and PG drop together in SETTLE
    pwr_req = 1'b1;
    wait_fsm(4'h3, 400, "em_settle_fsm");
    emerg   = 1'b1;
    pg_kill = 4'b0001;
    @(negedge clk);
    check_eq("em_type", 32'(fault_type), 32'd3);
    check_eq("em_rail", 32'(fault_rail), 32'd7);
    check_eq("em_en", 32'(rail_en), 32'd0);
    check_eq("em_fsm", 32'(fsm), 32'hF);
    emerg     = 1'b0;
    pg_kill   = '0;
    fault_clr = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("em_clr_ign_fsm", 32'(fsm), 32'hF);
    check_eq("em_clr_ign_type", 32'(fault_type), 32'd3);
    pwr_req = 1'b0;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("em_clr_fsm", 32'(fsm), 32'h9);
    check_eq("em_clr_type", 32'(fault_type), 32'd0);
    check_eq("em_clr_rail", 32'(fault_rail), 32'd0);
    check_eq("em_clr_fault_n", 32'(fault_n), 32'd1);
    repeat (4 * TickDiv) @(negedge clk);

    // Reset in the middle of rail 1 bring-up
    pwr_req = 1'b1;
    wait_en(4'b0011, 400, "mr_en_r1");
    check_eq("mr_pwrup_fsm", 32'(fsm), 32'h5);
    rst     = 1'b1;
    pwr_req = 1'b0;
    @(negedge clk);
    check_eq("mr_en", 32'(rail_en), 32'd0);
    check_eq("mr_fsm", 32'(fsm), 32'h9);
    check_eq("mr_fault_n", 32'(fault_n), 32'd1);
    check_eq("mr_fault_type", 32'(fault_type), 32'd0);
    check_eq("mr_fault_rail", 32'(fault_rail), 32'd0);
    check_eq("mr_all_pwrgd", 32'(all_pwrgd), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
